// File: rtl/calvera_issue_pkg.sv
// Shared types and widths for the ALU issue queue: the entry record, the tag widths,
// and the wakeup tag-compare helper.
package calvera_issue_pkg;

  localparam int DEPTH_DEFAULT = 8;
  localparam int PREG_W        = 6;
  localparam int ROB_W         = 6;
  localparam int PKT_W         = 2 * PREG_W + ROB_W;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] rs1;
    logic              rs1_rdy;
    logic [PREG_W-1:0] rs2;
    logic              rs2_rdy;
  } iq_entry_t;

  function automatic logic wake_hit(input logic              wk_valid,
                                    input logic [PREG_W-1:0] wk_dest,
                                    input logic [PREG_W-1:0] tag);
    return wk_valid && (tag == wk_dest);
  endfunction

endpackage

// File: rtl/iq_oldest_select.sv
// Priority selector for the issue queue. The lowest index is the oldest entry and wins.
// Outputs a one-hot grant vector and an any-grant flag.
module iq_oldest_select #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         any_grant
);

  // NOTE: every output of this combinational block is defaulted first, so no path can infer a latch.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !any_grant) begin
        grant[i]  = 1'b1;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing ALU issue queue: in-order enqueue, wakeup by tag broadcast, oldest-ready issue.
// Optional macro ALU_ISSUEQ_WAKEUP_BYPASS_EN lets a same-cycle wakeup feed the selector.
module alu_issue_queue
  import calvera_issue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                         cpu_clock_i,
  input  logic                         cpu_reset_i,
  input  logic                         flush_i,
  input  logic                         enq_valid_i,
  output logic                         enq_ready_o,
  input  logic [ROB_W-1:0]             enq_rob_i,
  input  logic [PREG_W-1:0]            enq_rs1_i,
  input  logic [PREG_W-1:0]            enq_rs2_i,
  input  logic                         enq_rs1_rdy_i,
  input  logic                         enq_rs2_rdy_i,
  input  logic [PREG_W-1:0]            wakeup_dest_i,
  input  logic                         wakeup_valid_i,
  output logic [PKT_W-1:0]             data_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH):0]       occupancy_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  iq_entry_t        q_r   [DEPTH];
  iq_entry_t        q_up  [DEPTH];
  iq_entry_t        q_nxt [DEPTH];
  iq_entry_t        enq_entry;
  iq_entry_t        sel_entry;
  logic [CNT_W-1:0] count_r, count_nxt, wr_idx;
  logic [DEPTH-1:0] req, grant;
  logic             any_grant, issue, enq, shift;

  assign enq_ready_o = (count_r < CNT_W'(DEPTH)) && !flush_i && !cpu_reset_i;
  assign enq         = enq_valid_i && enq_ready_o;
  assign issue       = any_grant && !flush_i;
  assign wr_idx      = count_r - CNT_W'(issue);
  assign count_nxt   = count_r + CNT_W'(enq) - CNT_W'(issue);
  assign occupancy_o = count_r;

  // Tag 0 is the hardwired-ready register; a same-cycle wakeup is captured at dispatch.
  always_comb begin
    enq_entry         = '0;
    enq_entry.valid   = 1'b1;
    enq_entry.rob     = enq_rob_i;
    enq_entry.rs1     = enq_rs1_i;
    enq_entry.rs2     = enq_rs2_i;
    enq_entry.rs1_rdy = enq_rs1_rdy_i || (enq_rs1_i == '0)
                        || wake_hit(wakeup_valid_i, wakeup_dest_i, enq_rs1_i);
    enq_entry.rs2_rdy = enq_rs2_rdy_i || (enq_rs2_i == '0)
                        || wake_hit(wakeup_valid_i, wakeup_dest_i, enq_rs2_i);
  end

  always_comb begin
    req = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef ALU_ISSUEQ_WAKEUP_BYPASS_EN
      req[i] = q_r[i].valid
               && (q_r[i].rs1_rdy || wake_hit(wakeup_valid_i, wakeup_dest_i, q_r[i].rs1))
               && (q_r[i].rs2_rdy || wake_hit(wakeup_valid_i, wakeup_dest_i, q_r[i].rs2));
`else
      req[i] = q_r[i].valid && q_r[i].rs1_rdy && q_r[i].rs2_rdy;
`endif
    end
  end

  iq_oldest_select #(.N(DEPTH)) u_select (
    .req       (req),
    .grant     (grant),
    .any_grant (any_grant)
  );

  // Entries at and above the granted slot slide down one place; then wakeups and the enqueue apply.
  always_comb begin
    sel_entry = '0;
    shift     = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) q_up[i] = q_r[i + 1];
    q_up[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_entry = q_r[i];
      shift    = shift || (issue && grant[i]);
      q_nxt[i] = shift ? q_up[i] : q_r[i];
      if (wake_hit(wakeup_valid_i, wakeup_dest_i, q_nxt[i].rs1)) q_nxt[i].rs1_rdy = 1'b1;
      if (wake_hit(wakeup_valid_i, wakeup_dest_i, q_nxt[i].rs2)) q_nxt[i].rs2_rdy = 1'b1;
      if (enq && (CNT_W'(i) == wr_idx)) q_nxt[i] = enq_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      // NOTE: the entry array is small flop storage, so it is cleared outright rather than just its valid bits.
      for (int i = 0; i < DEPTH; i++) q_r[i] <= '0;
      count_r <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) q_r[i].valid <= 1'b0;
      count_r <= '0;
      valid_o <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q_r[i] <= q_nxt[i];
      count_r <= count_nxt;
      valid_o <= issue;
      if (issue) data_o <= {sel_entry.rs2, sel_entry.rs1, sel_entry.rob};
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_alu_issue_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             cpu_clock_i = 1'b0;
  logic             cpu_reset_i, flush_i, enq_valid_i, enq_ready_o;
  logic [5:0]       enq_rob_i, enq_rs1_i, enq_rs2_i, wakeup_dest_i;
  logic             enq_rs1_rdy_i, enq_rs2_rdy_i, wakeup_valid_i;
  logic [17:0]      data_o;
  logic             valid_o;
  logic [CNT_W-1:0] occupancy_o;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .cpu_clock_i    (cpu_clock_i),
    .cpu_reset_i    (cpu_reset_i),
    .flush_i        (flush_i),
    .enq_valid_i    (enq_valid_i),
    .enq_ready_o    (enq_ready_o),
    .enq_rob_i      (enq_rob_i),
    .enq_rs1_i      (enq_rs1_i),
    .enq_rs2_i      (enq_rs2_i),
    .enq_rs1_rdy_i  (enq_rs1_rdy_i),
    .enq_rs2_rdy_i  (enq_rs2_rdy_i),
    .wakeup_dest_i  (wakeup_dest_i),
    .wakeup_valid_i (wakeup_valid_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .occupancy_o    (occupancy_o)
  );

  always #5 cpu_clock_i = ~cpu_clock_i;

  typedef struct {
    logic [5:0] rob, rs1, rs2;
    bit         r1, r2;
  } m_ent_t;

  m_ent_t      mq[$];
  bit          m_valid = 1'b0;
  logic [17:0] m_data  = '0;
  int          tests   = 0;
  int          fails   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit woke(input logic [5:0] tag);
    return wakeup_valid_i && (tag == wakeup_dest_i);
  endfunction

  function automatic bit sel_ready(input m_ent_t e);
`ifdef ALU_ISSUEQ_WAKEUP_BYPASS_EN
    return (e.r1 || woke(e.rs1)) && (e.r2 || woke(e.rs2));
`else
    return e.r1 && e.r2;
`endif
  endfunction

  // One clock: check the handshake mid-cycle, advance the model, check registered outputs after the edge.
  task automatic step();
    bit     exp_rdy;
    int     idx;
    m_ent_t e;
    @(negedge cpu_clock_i);
    exp_rdy = !cpu_reset_i && !flush_i && (mq.size() < DEPTH);
    check("enq_ready", 32'(enq_ready_o), 32'(exp_rdy));
    if (cpu_reset_i) begin
      mq.delete();
      m_valid = 1'b0;
      m_data  = '0;
    end else if (flush_i) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      idx = -1;
      foreach (mq[i]) if (idx < 0 && sel_ready(mq[i])) idx = i;
      m_valid = (idx >= 0);
      if (idx >= 0) begin
        m_data = {mq[idx].rs2, mq[idx].rs1, mq[idx].rob};
        mq.delete(idx);
      end
      foreach (mq[i]) begin
        if (woke(mq[i].rs1)) mq[i].r1 = 1'b1;
        if (woke(mq[i].rs2)) mq[i].r2 = 1'b1;
      end
      if (enq_valid_i && exp_rdy) begin
        e.rob = enq_rob_i;
        e.rs1 = enq_rs1_i;
        e.rs2 = enq_rs2_i;
        e.r1  = enq_rs1_rdy_i || (enq_rs1_i == 6'd0) || woke(enq_rs1_i);
        e.r2  = enq_rs2_rdy_i || (enq_rs2_i == 6'd0) || woke(enq_rs2_i);
        mq.push_back(e);
      end
    end
    @(posedge cpu_clock_i);
    #1;
    check("valid_o", 32'(valid_o), 32'(m_valid));
    check("data_o", 32'(data_o), 32'(m_data));
    check("occupancy", 32'(occupancy_o), 32'(mq.size()));
  endtask

  task automatic drive(input bit rst, input bit fl, input bit ev,
                       input logic [5:0] rob, input logic [5:0] rs1, input logic [5:0] rs2,
                       input bit r1, input bit r2, input bit wv, input logic [5:0] wd);
    cpu_reset_i    = rst;
    flush_i        = fl;
    enq_valid_i    = ev;
    enq_rob_i      = rob;
    enq_rs1_i      = rs1;
    enq_rs2_i      = rs2;
    enq_rs1_rdy_i  = r1;
    enq_rs2_rdy_i  = r2;
    wakeup_valid_i = wv;
    wakeup_dest_i  = wd;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic enq(input logic [5:0] rob, input logic [5:0] rs1, input logic [5:0] rs2,
                     input bit r1, input bit r2);
    drive(0, 0, 1, rob, rs1, rs2, r1, r2, 0, 0);
  endtask

  task automatic wake(input logic [5:0] tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, tag);
  endtask

  initial begin
    // Reset, with an enqueue offered that must be refused.
    drive(1, 0, 1, 6'h01, 6'h00, 6'h00, 1, 1, 0, 0);
    drive(1, 1, 1, 6'h01, 6'h00, 6'h00, 1, 1, 0, 0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_occ", 32'(occupancy_o), 32'd0);

    // Both sources ready at dispatch: issues at minimum latency.
    enq(6'h05, 6'h03, 6'h00, 1, 0);
    idle(1);
    check("min_lat_valid", 32'(valid_o), 32'd1);
    check("min_lat_data", 32'(data_o), 32'h000C5);
    check("min_lat_occ", 32'(occupancy_o), 32'd0);
    idle(1);
    check("valid_one_cycle", 32'(valid_o), 32'd0);
    check("data_hold", 32'(data_o), 32'h000C5);

    // Late wakeup of a waiting source.
    enq(6'h01, 6'h10, 6'h00, 0, 0);
    idle(2);
    wake(6'h10);
    idle(2);

    // Fill to capacity with waiting entries, then wake the fourth one.
    for (int i = 0; i < DEPTH; i++) enq(6'(8 + i), 6'(6'h20 + i), 6'h00, 0, 0);
    check("full_occ", 32'(occupancy_o), 32'd8);
    enq(6'h3F, 6'h00, 6'h00, 1, 1);
    wake(6'h23);
    idle(1);
    check("mid_issue_occ", 32'(occupancy_o), 32'd7);
    check("mid_issue_data", 32'(data_o), 32'({6'h00, 6'h23, 6'd11}));
    wake(6'h20);
    wake(6'h24);
    idle(2);

    // Two entries made ready together: the older one goes first.
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    enq(6'h30, 6'h30, 6'h00, 0, 0);
    enq(6'h31, 6'h31, 6'h00, 0, 0);
    enq(6'h32, 6'h30, 6'h00, 0, 0);
    wake(6'h30);
    idle(3);

    // Flush while an issue is being presented; a concurrent enqueue is dropped.
    for (int i = 0; i < 6; i++) enq(6'(6'h10 + i), (i == 0) ? 6'h39 : 6'h3A, 6'h00, 0, 0);
    wake(6'h39);
    idle(1);
    drive(0, 1, 1, 6'h2A, 6'h00, 6'h00, 1, 1, 0, 0);
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_occ", 32'(occupancy_o), 32'd0);

    // A source woken in its own dispatch cycle is stored ready.
    drive(0, 0, 1, 6'h07, 6'h22, 6'h00, 0, 0, 1, 6'h22);
    idle(1);
    check("byp_enq_valid", 32'(valid_o), 32'd1);
    idle(1);

    // Random traffic over a small tag space so wakeups hit often.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
            6'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1), 6'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entry count (power of two, 4..16).
REQ-002 SHALL have port cpu_clock_i  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port cpu_reset_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush_i  input  1  pipeline flush, discards all entries.
REQ-005 SHALL have port enq_valid_i  input  1  dispatch offers a micro-op.
REQ-006 SHALL have port enq_ready_o  output  1  queue accepts the offer this cycle.
REQ-007 SHALL have port enq_rob_i  input  6  ROB id; bit 0 also selects the fetch-pair slot.
REQ-008 SHALL have ports enq_rs1_i, enq_rs2_i  input  6 each  physical source tags.
REQ-009 SHALL have ports enq_rs1_rdy_i, enq_rs2_rdy_i  input  1 each  busy-table readiness at dispatch.
REQ-010 SHALL have ports wakeup_dest_i  input  6  and wakeup_valid_i  input  1  (broadcast from execute stage).
REQ-011 SHALL have port data_o  output  18  issue packet {rs2[17:12], rs1[11:6], rob[5:0]}.
REQ-012 SHALL have port valid_o  output  1  data_o holds an issued micro-op.
REQ-013 SHALL have port occupancy_o  output  $clog2(DEPTH)+1  valid entry count.

Function
REQ-014 Entry handshake: transfer occurs on cycle where enq_valid_i & enq_ready_o; enq_ready_o = (occupancy_o < DEPTH) & !flush_i.
REQ-015 When full, enq_ready_o SHALL be 0 even if an issue occurs that cycle.
REQ-016 Queue SHALL be collapsing: index 0 oldest; new entry written at index occupancy minus (1 if issuing this cycle).
REQ-017 Source tag 6'd0 SHALL always be treated as ready.
REQ-018 Each cycle with wakeup_valid_i, every valid entry source equal to wakeup_dest_i SHALL set its ready bit at that edge.
REQ-019 An enqueuing source matching a same-cycle wakeup SHALL be stored ready.
REQ-020 Selection SHALL pick the lowest-index valid entry with both sources ready; at most one issue per cycle.
REQ-021 Selected entry SHALL be removed and data_o/valid_o registered at the same edge; valid_o high exactly one cycle per issue.
REQ-022 With no ready entry, valid_o SHALL be 0 next cycle; data_o SHALL hold its last value.
REQ-023 Minimum latency: enqueued with both sources ready at edge N -> valid_o high in cycle after edge N+1.
REQ-024 flush_i SHALL override all: entries cleared, valid_o 0, enqueue and issue suppressed at that edge.
REQ-025 occupancy_o SHALL equal previous count + enq - issue, never exceeding DEPTH nor underflowing.

Reset
REQ-026 On cpu_reset_i at an edge: all entries invalid, occupancy_o 0, valid_o 0, data_o 18'd0; reset dominates flush_i.
REQ-027 enq_ready_o SHALL be 0 while cpu_reset_i is high.

Configuration
REQ-028 Macro ALU_ISSUEQ_WAKEUP_BYPASS_EN, when defined, SHALL let a wakeup in cycle N satisfy readiness for selection in cycle N (combinational tag compare into selector).
REQ-029 Without ALU_ISSUEQ_WAKEUP_BYPASS_EN, a woken entry SHALL be selectable no earlier than cycle N+1.

Structure
REQ-030 Package calvera_issue_pkg SHALL hold DEPTH default, PREG_W=6, ROB_W=6, and the entry struct {valid, rob, rs1, rs1_rdy, rs2, rs2_rdy}.
REQ-031 Sub-module iq_oldest_select SHALL implement the lowest-index ready priority select, outputting one-hot grant and any-grant.

Verification
REQ-032 Reset, then enqueue rob=6'h05 rs1=6'h03 rs2=6'h00 both ready -> two edges later valid_o=1, data_o=18'h000C5, occupancy 0.
REQ-033 Enqueue rob=1 rs1=6'h10 not ready; wakeup_dest_i=6'h10 three cycles later -> issue with valid_o next cycle (bypass off) or same-cycle select (bypass on).
REQ-034 Fill 8 non-ready entries -> enq_ready_o=0, occupancy_o=8; wake entry 3 -> it issues, occupancy 7, enq_ready_o=1, order of remaining preserved.
REQ-035 Entries 0 and 2 ready simultaneously -> entry 0 (older) issues first, entry 2 next cycle.
REQ-036 With 5 entries and valid_o=1, assert flush_i -> next cycle valid_o=0, occupancy_o=0, concurrent enqueue dropped.
REQ-037 Enqueue with rs1=6'h22 while wakeup_dest_i=6'h22 same cycle -> entry stored ready, issues at minimum latency.
